dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl_if.sv | 40 ++++
 rtl/dmem_ctrl.sv | 119 +++++++++++
 tb/tb_dmem_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Retire-stage data-memory request bus and the
// responder's load return / status lines.
interface dmem_ctrl_if;
    logic        dmem_wr_en_in;
    logic        dmem_rd_en_in;
    logic [31:0] dmem_addr_in;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_rd_data_out;
    logic        dmem_rd_valid_out;
    logic        sb_full_out;
    logic        sb_empty_out;
    logic        misaligned_err;
    logic        overflow_err;

    modport slave (
        input  dmem_wr_en_in,
        input  dmem_rd_en_in,
        input  dmem_addr_in,
        input  dmem_data_in,
        output dmem_rd_data_out,
        output dmem_rd_valid_out,
        output sb_full_out,
        output sb_empty_out,
        output misaligned_err,
        output overflow_err
    );

    modport master (
        output dmem_wr_en_in,
        output dmem_rd_en_in,
        output dmem_addr_in,
        output dmem_data_in,
        input  dmem_rd_data_out,
        input  dmem_rd_valid_out,
        input  sb_full_out,
        input  sb_empty_out,
        input  misaligned_err,
        input  overflow_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory responder: word RAM behind an in-order
// store buffer with youngest-match load forwarding.
module dmem_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int SB_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus
);
    localparam int ADDR_BITS = $clog2(MEM_WORDS);
    localparam int PTR_BITS  = $clog2(SB_DEPTH);
    localparam int CNT_BITS  = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(SB_DEPTH);

    typedef logic [ADDR_BITS-1:0] word_t;
    typedef logic [PTR_BITS-1:0]  ptr_t;

    logic [31:0] ram [MEM_WORDS];
    word_t       sb_word [SB_DEPTH];
    logic [31:0] sb_data [SB_DEPTH];

    ptr_t                head;
    ptr_t                tail;
    logic [CNT_BITS-1:0] count;

    logic [31:0] rd_data;
    logic        rd_valid;
    logic        mis_err;
    logic        ovf_err;

    word_t word;
    logic  aligned;
    logic  ld_req;
    logic  ld_acc;
    logic  st_req;
    logic  st_acc;
    logic  st_drop;
    logic  drain;
    logic  bad;
    logic  full;

    logic        fwd_hit;
    logic [31:0] fwd_data;
    ptr_t        idx;

    logic unused_addr;
    assign unused_addr = ^bus.dmem_addr_in[31:ADDR_BITS+2];

    assign word    = bus.dmem_addr_in[ADDR_BITS+1:2];
    assign aligned = (bus.dmem_addr_in[1:0] == 2'b00);
    assign full    = (count == FULL);

    // An aligned load owns the RAM port even when a same-cycle
    // store wins the request, so it still blocks the drain.
    assign ld_req  = !rst && bus.dmem_rd_en_in && aligned;
    assign ld_acc  = ld_req && !bus.dmem_wr_en_in;
    assign st_req  = !rst && bus.dmem_wr_en_in && aligned;
    assign drain   = !rst && !ld_req && (count != '0);
    assign st_acc  = st_req && (!full || drain);
    assign st_drop = st_req && full && !drain;
    assign bad     = !rst && (bus.dmem_wr_en_in || bus.dmem_rd_en_in)
                     && !aligned;

    // Scan oldest to youngest so the last match is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head + PTR_BITS'(i);
            if (CNT_BITS'(i) < count && sb_word[idx] == word) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            mis_err  <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            rd_valid <= ld_acc;
            if (ld_acc)
                rd_data <= fwd_hit ? fwd_data : ram[word];
            mis_err <= bad;
            if (st_drop)
                ovf_err <= 1'b1;
            if (drain)
                head <= head + 1'b1;
            if (st_acc)
                tail <= tail + 1'b1;
            count <= count + CNT_BITS'(st_acc) - CNT_BITS'(drain);
        end
    end

    // Storage arrays carry no reset; RAM survives rst by design.
    always_ff @(posedge clk) begin
        if (st_acc) begin
            sb_word[tail] <= word;
            sb_data[tail] <= bus.dmem_data_in;
        end
        if (drain)
            ram[sb_word[head]] <= sb_data[head];
    end

    assign bus.dmem_rd_data_out  = rd_data;
    assign bus.dmem_rd_valid_out = rd_valid;
    assign bus.sb_full_out       = full;
    assign bus.sb_empty_out      = (count == '0);
    assign bus.misaligned_err    = mis_err;
    assign bus.overflow_err      = ovf_err;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl against a queue-based
// store-buffer / memory reference model.
module tb_dmem_ctrl;
    localparam int SBD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_ctrl_if bus();

    dmem_ctrl #(
        .MEM_WORDS(1024),
        .SB_DEPTH (SBD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [9:0]  w;
        logic [31:0] d;
    } ent_t;

    int n_checks = 0;
    int n_fails  = 0;

    ent_t        sbq[$];
    logic [31:0] mem_m [1024];
    logic [31:0] e_rdata = '0;
    logic        e_valid = 1'b0;
    logic        e_mis   = 1'b0;
    logic        e_ovf   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_addr(input int sel, input bit mis);
        logic [31:0] a;
        int          wd;
        wd = (sel < 12) ? sel : 1008 + sel;
        a  = 32'($urandom()) & 32'hFFFF_F000;
        a  = a | (32'(wd) << 2);
        if (mis)
            a = a | 32'($urandom_range(1, 3));
        return a;
    endfunction

    task automatic model(input logic r, input logic w, input logic rd,
                         input logic [31:0] a, input logic [31:0] d);
        logic [9:0] wd;
        bit         al;
        bit         found;
        ent_t       h;
        wd    = a[11:2];
        al    = (a[1:0] == 2'b00);
        found = 0;
        if (r) begin
            sbq.delete();
            e_rdata = '0;
            e_valid = 1'b0;
            e_mis   = 1'b0;
            e_ovf   = 1'b0;
            return;
        end
        e_mis   = (w || rd) && !al;
        e_valid = rd && al && !w;
        if (e_valid) begin
            for (int i = sbq.size() - 1; i >= 0; i--)
                if (!found && sbq[i].w == wd) begin
                    e_rdata = sbq[i].d;
                    found   = 1;
                end
            if (!found)
                e_rdata = mem_m[wd];
        end
        if (!(rd && al) && sbq.size() > 0) begin
            h = sbq.pop_front();
            mem_m[h.w] = h.d;
        end
        if (w && al) begin
            if (sbq.size() < SBD)
                sbq.push_back('{wd, d});
            else
                e_ovf = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd,
                        input logic [31:0] a, input logic [31:0] d);
        rst                   = r;
        bus.dmem_wr_en_in     = w;
        bus.dmem_rd_en_in     = rd;
        bus.dmem_addr_in      = a;
        bus.dmem_data_in      = d;
        @(posedge clk);
        model(r, w, rd, a, d);
        @(negedge clk);
        check("rd_valid", 32'(bus.dmem_rd_valid_out), 32'(e_valid));
        check("rd_data",  bus.dmem_rd_data_out, e_rdata);
        check("mis_err",  32'(bus.misaligned_err), 32'(e_mis));
        check("ovf_err",  32'(bus.overflow_err), 32'(e_ovf));
        check("sb_full",  32'(bus.sb_full_out), 32'(sbq.size() == SBD));
        check("sb_empty", 32'(bus.sb_empty_out), 32'(sbq.size() == 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic ld(input logic [31:0] a);
        step(1'b0, 1'b0, 1'b1, a, '0);
    endtask

    logic [31:0] pre [3];
    logic [31:0] a6  [3];

    initial begin
        bus.dmem_wr_en_in = 1'b0;
        bus.dmem_rd_en_in = 1'b0;
        bus.dmem_addr_in  = '0;
        bus.dmem_data_in  = '0;

        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h10, 32'h1234);
        check("rst_rdata", bus.dmem_rd_data_out, 32'h0);
        check("rst_empty", 32'(bus.sb_empty_out), 32'h1);

        for (int s = 0; s < 16; s++)
            st(mk_addr(s, 1'b0), 32'($urandom()));
        idle(6);

        // 1: plain store then load after drain
        st(32'h10, 32'hDEAD_BEEF);
        idle(2);
        ld(32'h10);
        check("t1_data",  bus.dmem_rd_data_out, 32'hDEAD_BEEF);
        check("t1_valid", 32'(bus.dmem_rd_valid_out), 32'h1);
        check("t1_empty", 32'(bus.sb_empty_out), 32'h1);

        // 2: youngest-match forwarding
        st(32'h20, 32'h1);
        st(32'h20, 32'h2);
        ld(32'h20);
        check("t2_fwd", bus.dmem_rd_data_out, 32'h2);
        idle(4);

        // 4: misaligned store and load
        st(32'h13, 32'h7777_7777);
        check("t4_st_mis",   32'(bus.misaligned_err), 32'h1);
        check("t4_st_empty", 32'(bus.sb_empty_out), 32'h1);
        ld(32'h13);
        check("t4_ld_mis",   32'(bus.misaligned_err), 32'h1);
        check("t4_ld_valid", 32'(bus.dmem_rd_valid_out), 32'h0);

        // 5: full buffer, store without load drains and accepts
        for (int j = 0; j < 4; j++)
            step(1'b0, 1'b1, 1'b1, mk_addr(j, 1'b0), 32'hA000_0000 + j);
        check("t5_full", 32'(bus.sb_full_out), 32'h1);
        st(mk_addr(5, 1'b0), 32'hCAFE_0005);
        check("t5_full2", 32'(bus.sb_full_out), 32'h1);
        check("t5_noovf", 32'(bus.overflow_err), 32'h0);
        idle(6);

        // 3: loads every cycle, five stores -> overflow
        for (int j = 0; j < 5; j++) begin
            step(1'b0, 1'b1, 1'b1, mk_addr(6 + j, 1'b0), 32'h5555_0000 + j);
            if (j == 3)
                check("t3_full", 32'(bus.sb_full_out), 32'h1);
        end
        check("t3_ovf", 32'(bus.overflow_err), 32'h1);
        for (int j = 0; j < 3; j++)
            ld(mk_addr(j, 1'b0));
        idle(6);
        ld(mk_addr(10, 1'b0));
        check("t3_ovf_sticky", 32'(bus.overflow_err), 32'h1);

        // 6: reset discards pending stores
        for (int j = 0; j < 3; j++) begin
            a6[j]  = mk_addr(1 + j, 1'b0);
            pre[j] = mem_m[a6[j][11:2]];
        end
        for (int j = 0; j < 3; j++)
            step(1'b0, 1'b1, 1'b1, a6[j], 32'hBAD0_0000 + j);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("t6_empty", 32'(bus.sb_empty_out), 32'h1);
        check("t6_ovf",   32'(bus.overflow_err), 32'h0);
        idle(3);
        for (int j = 0; j < 3; j++) begin
            ld(a6[j]);
            check("t6_pre", bus.dmem_rd_data_out, pre[j]);
        end

        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 40,
                 mk_addr(int'($urandom_range(0, 15)),
                         $urandom_range(0, 19) == 0),
                 32'($urandom()));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end
endmodule
